// File: rtl/elev_pkg.sv
// Shared constants, state encoding and floor-mask helpers for the
// three-floor elevator controller.
package elev_pkg;

  localparam int PISO_W = 2;
  localparam int CNT_W  = 4;

  localparam logic [PISO_W-1:0] PISO_MIN = 2'd0;
  localparam logic [PISO_W-1:0] PISO_MAX = 2'd2;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUBIR  = 2'd1,
    BAJAR  = 2'd2,
    PUERTA = 2'd3
  } estado_t;

  // One-hot request bit for a floor.
  function automatic logic [2:0] floor_bit(input logic [PISO_W-1:0] p);
    return 3'b001 << p;
  endfunction

  // Request bits strictly above floor p.
  function automatic logic [2:0] above_mask(input logic [PISO_W-1:0] p);
    case (p)
      PISO_MIN: return 3'b110;
      2'd1:     return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

  // Request bits strictly below floor p.
  function automatic logic [2:0] below_mask(input logic [PISO_W-1:0] p);
    case (p)
      PISO_MIN: return 3'b000;
      2'd1:     return 3'b001;
      default:  return 3'b011;
    endcase
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Tick counter for travel and door timing. Clears on request, advances on
// each enabled tick and flags the tick on which it sits at its limit.
// ELEV_CLK_DIV_EN: build an internal prescaler that generates the tick
// from clk every DIV cycles; otherwise the external tick_i is used.
module elev_timer
  import elev_pkg::*;
#(
  parameter int unsigned DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] lim_i,
  output logic             tc_o
);

  logic             tick_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef ELEV_CLK_DIV_EN
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;

  // Prescaler wraps at DIV-1; the wrap cycle is the tick.
  always_comb begin
    pre_d = (pre_q == PRE_W'(DIV - 1)) ? '0 : pre_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

  assign tick_eff = (pre_q == PRE_W'(DIV - 1));
`else
  // A zero DIV means no timebase at all, so the tick is suppressed.
  assign tick_eff = tick_i & (DIV != 0);
`endif

  // Clear wins over counting; counting only on an enabled tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                cnt_d = '0;
    else if (en_i && tick_eff) cnt_d = cnt_q + 1'b1;
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = en_i & tick_eff & (cnt_q == lim_i);

endmodule

// File: rtl/elevador_ctrl_3p.sv
// Three-floor elevator scheduler: latches floor requests, picks a travel
// direction (keeping the current one while requests remain that way) and
// drives motor, door and status outputs. Timing comes from elev_timer.
// ELEV_CLK_DIV_EN selects the internal prescaler inside elev_timer.
module elevador_ctrl_3p
  import elev_pkg::*;
#(
  parameter int          T_VIAJE  = 4,
  parameter int          T_PUERTA = 3,
  parameter int unsigned DIV      = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] btn,
  output logic [1:0] piso,
  output logic       motor_sub,
  output logic       motor_baj,
  output logic       puerta,
  output logic [2:0] pend,
  output logic [1:0] estado
);

  estado_t           estado_q, estado_d;
  logic              dir_q, dir_d;
  logic [PISO_W-1:0] piso_q, piso_d, piso_nx;
  logic [2:0]        pend_q, pend_d, req;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0]  cnt_lim;

  elev_timer #(.DIV(DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .lim_i  (cnt_lim),
    .tc_o   (cnt_tc)
  );

  // Next state, direction, floor and request latch; timer control.
  always_comb begin
    estado_d = estado_q;
    dir_d    = dir_q;
    piso_d   = piso_q;
    piso_nx  = piso_q;
    req      = pend_q | btn;
    pend_d   = req;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_lim  = CNT_W'(T_VIAJE - 1);
    case (estado_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if ((req & floor_bit(piso_q)) != 3'b000) begin
          estado_d = PUERTA;
          pend_d   = req & ~floor_bit(piso_q);
        end else if ((req & above_mask(piso_q)) != 3'b000 &&
                     (req & below_mask(piso_q)) != 3'b000) begin
          estado_d = (dir_q == UP) ? SUBIR : BAJAR;
        end else if ((req & above_mask(piso_q)) != 3'b000) begin
          estado_d = SUBIR;
          dir_d    = UP;
        end else if ((req & below_mask(piso_q)) != 3'b000) begin
          estado_d = BAJAR;
          dir_d    = DOWN;
        end
      end
      SUBIR, BAJAR: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          piso_nx = (estado_q == SUBIR) ? piso_q + 2'd1 : piso_q - 2'd1;
          piso_d  = piso_nx;
          if ((req & floor_bit(piso_nx)) != 3'b000) begin
            estado_d = PUERTA;
            pend_d   = req & ~floor_bit(piso_nx);
          end else if (((dir_q == UP) ? (req & above_mask(piso_nx))
                                      : (req & below_mask(piso_nx))) == 3'b000) begin
            estado_d = IDLE;
          end
        end
      end
      PUERTA: begin
        cnt_en  = 1'b1;
        cnt_lim = CNT_W'(T_PUERTA - 1);
        pend_d  = req & ~floor_bit(piso_q);
        if (btn[piso_q]) begin
          // Door-hold: keep restarting the open time.
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          if (dir_q == UP) begin
            if ((pend_d & above_mask(piso_q)) != 3'b000) begin
              estado_d = SUBIR;
            end else if ((pend_d & below_mask(piso_q)) != 3'b000) begin
              estado_d = BAJAR;
              dir_d    = DOWN;
            end else begin
              estado_d = IDLE;
            end
          end else begin
            if ((pend_d & below_mask(piso_q)) != 3'b000) begin
              estado_d = BAJAR;
            end else if ((pend_d & above_mask(piso_q)) != 3'b000) begin
              estado_d = SUBIR;
              dir_d    = UP;
            end else begin
              estado_d = IDLE;
            end
          end
        end
      end
      default: begin
        estado_d = IDLE;
        cnt_clr  = 1'b1;
      end
    endcase
  end

  // State, direction, floor and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      dir_q    <= UP;
      piso_q   <= PISO_MIN;
      pend_q   <= 3'b000;
    end else begin
      estado_q <= estado_d;
      dir_q    <= dir_d;
      piso_q   <= piso_d;
      pend_q   <= pend_d;
    end
  end

  assign piso      = piso_q;
  assign pend      = pend_q;
  assign estado    = estado_q;
  assign motor_sub = (estado_q == SUBIR);
  assign motor_baj = (estado_q == BAJAR);
  assign puerta    = (estado_q == PUERTA);

endmodule

// File: tb/tb_elevador_ctrl_3p.sv
// Bench for elevador_ctrl_3p: directed scenarios followed by random traffic,
// checked cycle by cycle against a floor/request model of the elevator.
module tb_elevador_ctrl_3p;

  localparam int T_VIAJE  = 4;
  localparam int T_PUERTA = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [2:0] btn;
  logic [1:0] piso;
  logic       motor_sub, motor_baj, puerta;
  logic [2:0] pend;
  logic [1:0] estado;

  elevador_ctrl_3p #(.T_VIAJE(T_VIAJE), .T_PUERTA(T_PUERTA), .DIV(50000000)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn       (btn),
    .piso      (piso),
    .motor_sub (motor_sub),
    .motor_baj (motor_baj),
    .puerta    (puerta),
    .pend      (pend),
    .estado    (estado)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scoreboard.
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: floor number, preferred direction (+1/-1), motion
  // (+1 up, -1 down, 0 stopped), door flag, elapsed ticks, request set.
  int m_floor = 0;
  int m_dir   = 1;
  int m_move  = 0;
  int m_ticks = 0;
  bit m_door  = 1'b0;
  bit m_req[3];

  function automatic bit want(input int f, input int d);
    for (int i = 0; i < 3; i++)
      if ((i - f) * d > 0 && m_req[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input bit r, input logic [2:0] b, input bit t);
    bit up, dn;
    if (r) begin
      m_floor = 0; m_dir = 1; m_move = 0; m_ticks = 0; m_door = 1'b0;
      for (int i = 0; i < 3; i++) m_req[i] = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) if (b[i]) m_req[i] = 1'b1;
    if (m_door) begin
      m_req[m_floor] = 1'b0;
      if (b[m_floor]) m_ticks = 0;
      else if (t) begin
        m_ticks++;
        if (m_ticks == T_PUERTA) begin
          m_ticks = 0;
          m_door  = 1'b0;
          if (want(m_floor, m_dir)) m_move = m_dir;
          else if (want(m_floor, -m_dir)) begin
            m_dir  = -m_dir;
            m_move = m_dir;
          end
        end
      end
    end else if (m_move != 0) begin
      if (t) begin
        m_ticks++;
        if (m_ticks == T_VIAJE) begin
          m_ticks = 0;
          m_floor = m_floor + m_move;
          if (m_req[m_floor]) begin
            m_req[m_floor] = 1'b0;
            m_move = 0;
            m_door = 1'b1;
          end else if (!want(m_floor, m_move)) begin
            m_move = 0;
          end
        end
      end
    end else begin
      if (m_req[m_floor]) begin
        m_req[m_floor] = 1'b0;
        m_door = 1'b1;
      end else begin
        up = want(m_floor, 1);
        dn = want(m_floor, -1);
        if (up && dn) m_move = m_dir;
        else if (up) begin m_move = 1;  m_dir = 1;  end
        else if (dn) begin m_move = -1; m_dir = -1; end
      end
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [1:0] st;
    logic [2:0] p;
    st = m_door ? 2'd3 : (m_move > 0 ? 2'd1 : (m_move < 0 ? 2'd2 : 2'd0));
    p  = {m_req[2], m_req[1], m_req[0]};
    return {2'(m_floor), m_move > 0, m_move < 0, m_door, p, st};
  endfunction

  // Driver: one clk of stimulus, with the expected post-edge outputs queued.
  task automatic step(input bit r, input logic [2:0] b, input bit t);
    @(negedge clk);
    rst  = r;
    btn  = b;
    tick = t;
    model_step(r, b, t);
    exp_q.push_back(model_out());
  endtask

  // n idle cycles with a tick every per cycles (first cycle ticks).
  task automatic run(input int n, input int per);
    for (int k = 0; k < n; k++) step(1'b0, 3'b000, (k % per) == 0);
  endtask

  // Monitor: compare DUT outputs just after each edge.
  always @(posedge clk) begin : monitor
    logic [9:0] got, e;
    #1;
    if (exp_q.size() > 0) begin
      got = {piso, motor_sub, motor_baj, puerta, pend, estado};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got piso=%0d sub=%b baj=%b door=%b pend=%b st=%0d exp piso=%0d sub=%b baj=%b door=%b pend=%b st=%0d",
                 $time, got[9:8], got[7], got[6], got[5], got[4:2], got[1:0],
                 e[9:8], e[7], e[6], e[5], e[4:2], e[1:0]);
      end
    end
  end

  // Stimulus.
  initial begin
    rst  = 1'b1;
    btn  = 3'b000;
    tick = 1'b0;

    // Reset for two cycles.
    step(1'b1, 3'b000, 1'b1);
    step(1'b1, 3'b000, 1'b1);
    run(3, 1);

    // Call to floor 2 from floor 0: pass floor 1, door at 2, back to idle.
    step(1'b0, 3'b100, 1'b1);
    run(20, 1);

    // Return trip to floor 0, then a call at the current floor.
    step(1'b0, 3'b001, 1'b1);
    run(20, 1);
    step(1'b0, 3'b001, 1'b1);
    run(6, 1);

    // Requests for 1 and 2; floor 0 requested during the door at floor 1.
    step(1'b0, 3'b110, 1'b1);
    run(5, 1);
    step(1'b0, 3'b001, 1'b1);
    run(35, 1);

    // Door-hold at floor 0.
    step(1'b0, 3'b001, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 3'b001, 1'b1);
    run(6, 1);

    // Slow timebase: one tick every 5 clk.
    step(1'b0, 3'b010, 1'b0);
    run(40, 5);

    // Reset mid-travel.
    step(1'b0, 3'b001, 1'b1);
    run(2, 1);
    step(1'b1, 3'b000, 1'b0);
    run(3, 1);

    // Random traffic with sparse buttons, random ticks and rare resets.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 299) == 0,
           ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
           $urandom_range(0, 1) == 1);
    end
    run(40, 1);

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
